uart_rx: RTL and testbench

//  Serial-to-AXI4-Stream UART receiver; the receive-side counterpart of uart_tx in the UART block.

---
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1-style frame recovery from rxd onto an AXI4-Stream master port.
// The bit time is prescale*8 clk cycles; each bit is sampled at its centre through a 2-flop synchroniser.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                r_state;
    logic                  r_rxd_meta;
    logic                  r_rxs;
    logic [18:0]           r_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_frame;

    // Reload values: a whole bit time, and half a bit time to land on the start-bit centre.
    logic [18:0] w_bit_load;
    logic [18:0] w_half_load;
    assign w_bit_load  = {prescale, 3'b000} - 19'd1;
    assign w_half_load = {1'b0, prescale, 2'b00} - 19'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxd_meta <= 1'b1;
            r_rxs      <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxs      <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
            if (r_tvalid && m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        r_cnt   <= w_half_load;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (r_cnt != 19'd0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else if (!r_rxs) begin
                        r_cnt     <= w_bit_load;
                        r_bit_cnt <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        // Line was back high at the start centre: treat as a glitch.
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (r_cnt != 19'd0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else begin
                        r_shift   <= {r_rxs, r_shift[DATA_WIDTH-1:1]};
                        r_cnt     <= w_bit_load;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(DATA_WIDTH - 1)) begin
                            r_state <= ST_STOP;
                        end
                    end
                end

                ST_STOP: begin
                    if (r_cnt != 19'd0) begin
                        r_cnt <= r_cnt - 19'd1;
                    end else if (r_rxs) begin
                        // Delivery overrides the handshake clear above; a pending unaccepted word is lost.
                        r_tdata   <= r_shift;
                        r_tvalid  <= 1'b1;
                        r_overrun <= r_tvalid && !m_axis_tready;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_frame <= 1'b1;
                        r_state <= ST_BREAK;
                    end
                end

                ST_BREAK: begin
                    if (r_rxs) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign busy          = r_busy;
    assign overrun_error = r_overrun;
    assign frame_error   = r_frame;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: reset, table of single frames, corner-case sequences, and
// randomized frames compared against an ideal queue of expected words.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        rxd;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;
    logic [15:0] prescale;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .prescale      (prescale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit rand_ready = 1'b0;

    // Monitor: inputs change just after posedge, so at negedge they are stable for the next edge.
    logic [7:0] got_q[$];
    int         n_ovr = 0;
    int         n_ferr = 0;
    int         n_unstable = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            if (overrun_error) n_ovr++;
            if (frame_error) n_ferr++;
            if (prev_hold && m_axis_tvalid && !overrun_error && m_axis_tdata != prev_data) n_unstable++;
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
        end
    endtask

    // Ideal transmitter: every bit held for exactly 8*p clock cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        rxd = 1'b0;
        wait_clks(8 * p);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_clks(8 * p);
        end
        rxd = stop;
        wait_clks(8 * p);
    endtask

    typedef struct {
        int         p;
        logic [7:0] d;
        logic       stop;
        int         exp_beats;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int b0, f0, o0, k;
        logic [7:0] exp_q[$];
        int exp_ferr;

        rst = 1'b1;
        rxd = 1'b1;
        m_axis_tready = 1'b1;
        prescale = 16'd1;
        wait_clks(4);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun_error, 0);
        check("reset_frame", frame_error, 0);
        rst = 1'b0;
        wait_clks(4);

        vecs[0] = '{1, 8'hA5, 1'b1, 1, 0};
        vecs[1] = '{2, 8'h3C, 1'b0, 0, 1};
        vecs[2] = '{4, 8'h00, 1'b1, 1, 0};
        vecs[3] = '{3, 8'hFF, 1'b1, 1, 0};
        vecs[4] = '{1, 8'h55, 1'b1, 1, 0};
        vecs[5] = '{2, 8'h81, 1'b1, 1, 0};

        for (int v = 0; v < 6; v++) begin
            b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
            prescale = 16'(vecs[v].p);
            send_frame(vecs[v].d, vecs[v].stop, vecs[v].p);
            if (!vecs[v].stop) begin
                wait_clks(30);
                check("break_busy", busy, 1);
                rxd = 1'b1;
            end
            wait_clks(8 * vecs[v].p);
            check("vec_beats", got_q.size() - b0, vecs[v].exp_beats);
            if (vecs[v].exp_beats == 1 && got_q.size() > b0) check("vec_data", got_q[b0], vecs[v].d);
            check("vec_ferr", n_ferr - f0, vecs[v].exp_ferr);
            check("vec_ovr", n_ovr - o0, 0);
            check("vec_busy_after", busy, 0);
            $display("vector %0d: p=%0d data=0x%02h stop=%0b beats=%0d ferr=%0d", v, vecs[v].p,
                     vecs[v].d, vecs[v].stop, got_q.size() - b0, n_ferr - f0);
        end

        // Short low glitch in idle: start rejected at the start-bit centre.
        prescale = 16'd4;
        b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        rxd = 1'b0;
        wait_clks(2);
        rxd = 1'b1;
        wait_clks(2);
        check("glitch_busy_high", busy, 1);
        wait_clks(21);
        check("glitch_busy_low", busy, 0);
        check("glitch_beats", got_q.size() - b0, 0);
        check("glitch_errs", (n_ferr - f0) + (n_ovr - o0), 0);
        $display("glitch: busy returned low, no output");

        // Latency from rxd fall to tvalid rise.
        prescale = 16'd1;
        wait_clks(4);
        k = 0;
        fork
            send_frame(8'h96, 1'b1, 1);
            begin
                while (k < 200 && !m_axis_tvalid) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
            end
        join
        check("latency_p1", k, 2 + 4 + 8 * 9 + 1);
        $display("latency: %0d cycles", k);
        wait_clks(4);

        // Overrun: two words with the sink stalled.
        b0 = got_q.size(); o0 = n_ovr; f0 = n_ferr;
        m_axis_tready = 1'b0;
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        wait_clks(5);
        check("ovr_pulses", n_ovr - o0, 1);
        check("ovr_tvalid", m_axis_tvalid, 1);
        check("ovr_tdata", m_axis_tdata, 8'h22);
        check("ovr_no_beat", got_q.size() - b0, 0);
        m_axis_tready = 1'b1;
        wait_clks(3);
        check("ovr_beats", got_q.size() - b0, 1);
        if (got_q.size() > b0) check("ovr_beat_data", got_q[b0], 8'h22);
        check("ovr_tvalid_drop", m_axis_tvalid, 0);
        $display("overrun: pulses=%0d delivered=0x%02h", n_ovr - o0, m_axis_tdata);

        // Back-to-back frames.
        b0 = got_q.size(); o0 = n_ovr; f0 = n_ferr;
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h55, 1'b1, 1);
        wait_clks(10);
        check("b2b_beats", got_q.size() - b0, 3);
        if (got_q.size() >= b0 + 3) begin
            check("b2b_0", got_q[b0], 8'h00);
            check("b2b_1", got_q[b0 + 1], 8'hFF);
            check("b2b_2", got_q[b0 + 2], 8'h55);
        end
        check("b2b_errs", (n_ovr - o0) + (n_ferr - f0), 0);
        $display("back-to-back: %0d beats", got_q.size() - b0);

        // Reset in the middle of the data bits of 0x5A.
        b0 = got_q.size();
        prescale = 16'd2;
        rxd = 1'b0;
        wait_clks(16);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0] ? 1'b1 : 1'b0;
            wait_clks(16);
        end
        rst = 1'b1;
        rxd = 1'b1;
        wait_clks(2);
        check("rst_mid_tdata", m_axis_tdata, 0);
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_errs", overrun_error + frame_error, 0);
        rst = 1'b0;
        wait_clks(4);
        send_frame(8'hC3, 1'b1, 2);
        wait_clks(16);
        check("rst_mid_beats", got_q.size() - b0, 1);
        if (got_q.size() > b0) check("rst_mid_data", got_q[b0], 8'hC3);
        $display("reset mid-frame: beats after reset=%0d", got_q.size() - b0);

        // Randomized frames with random backpressure against an ideal word queue.
        b0 = got_q.size(); f0 = n_ferr; o0 = n_ovr;
        exp_ferr = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d;
            logic       stop;
            int         p;
            d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            p = $urandom_range(1, 3);
            prescale = 16'(p);
            send_frame(d, stop, p);
            if (stop) exp_q.push_back(d);
            else begin
                exp_ferr++;
                wait_clks($urandom_range(5, 20));
                rxd = 1'b1;
            end
            wait_clks(8 * p * $urandom_range(1, 3));
            $display("random %0d: p=%0d data=0x%02h stop=%0b", n, p, d, stop);
        end
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        wait_clks(20);
        check("rand_beats", got_q.size() - b0, exp_q.size());
        for (int i = 0; i < exp_q.size() && b0 + i < got_q.size(); i++) begin
            check("rand_data", got_q[b0 + i], exp_q[i]);
        end
        check("rand_ferr", n_ferr - f0, exp_ferr);
        check("rand_ovr", n_ovr - o0, 0);
        check("rand_busy", busy, 0);
        check("tdata_stability", n_unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
